prog_clk_div: RTL and testbench

PROG_CLK_DIV -- requirements
Module: prog_clk_div

---
 rtl/prog_clk_div.sv | 170 +++++++++++++++++
 tb/tb_prog_clk_div.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_clk_div.sv
// ---------------------------------------------------------------------------
// prog_clk_div
//
// Purpose:
//   A bank of CHANNELS independent programmable clock dividers. Each channel
//   divides iClk by a period P and holds its output high for the first H
//   cycles of every period. It also emits a one-cycle tick at the start of
//   each period. New P/H values are written into a per-channel shadow and
//   reach the active registers only at a period boundary. The period that
//   is running always finishes with the values it started with, so the
//   output never glitches.
//
// Parameters:
//   WIDTH          width of the period/high-time registers and counters
//   CHANNELS       number of divider channels (1..16)
//   DEFAULT_PERIOD period loaded at reset (high time = DEFAULT_PERIOD/2)
//
// Ports:
//   iClk         clock, all state updates on the rising edge
//   iRst_n       asynchronous active-low reset
//   iEn          per-channel run enable (bit i -> channel i)
//   iLoadValid   configuration load request
//   oLoadReady   load can be accepted this cycle (combinational)
//   iLoadCh      target channel of the load
//   iLoadPeriod  requested period in iClk cycles (0 and 1 behave as 2)
//   iLoadHigh    requested high time in iClk cycles
//   oClk         divided clock per channel (registered)
//   oTick        one-cycle pulse at each period start (registered)
// ---------------------------------------------------------------------------
module prog_clk_div #(
    parameter int WIDTH          = 16,
    parameter int CHANNELS       = 4,
    parameter int DEFAULT_PERIOD = 4
) (
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic [CHANNELS-1:0] iEn,
    input  logic                iLoadValid,
    output logic                oLoadReady,
    input  logic [3:0]          iLoadCh,
    input  logic [WIDTH-1:0]    iLoadPeriod,
    input  logic [WIDTH-1:0]    iLoadHigh,
    output logic [CHANNELS-1:0] oClk,
    output logic [CHANNELS-1:0] oTick
);

    localparam logic [WIDTH-1:0] DefPeriod = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] DefHigh   = WIDTH'(DEFAULT_PERIOD / 2);
    localparam logic [WIDTH-1:0] DefCnt    = WIDTH'(DEFAULT_PERIOD - 1);
    localparam logic [WIDTH-1:0] MinPeriod = WIDTH'(2);
    localparam logic [WIDTH-1:0] One       = WIDTH'(1);
    localparam logic [4:0]       ChanLimit = 5'(CHANNELS);

    // Pending flags of all channels, gathered so the ready logic can look
    // up the addressed channel.
    logic [CHANNELS-1:0] pend;

    // Padded to 16 entries so any 4-bit iLoadCh indexes a real bit. Entries
    // past CHANNELS stay 0, and the range check below masks them anyway.
    logic [15:0] pendWide;
    logic        chanInRange;
    logic        loadAccept;

    always_comb begin
        pendWide = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pendWide[i] = pend[i];
        end
    end

    // Load handshake: a transfer happens on a rising edge where both
    // iLoadValid and oLoadReady are 1. oLoadReady depends only on iLoadCh
    // and the pending flags, never on iLoadValid. The requester may hold
    // iLoadValid high while waiting, and the load data is sampled only on
    // the accepting edge. A channel with a load still waiting in its shadow
    // is not ready. An out-of-range channel index is never ready, so such a
    // request changes nothing.
    assign chanInRange = ({1'b0, iLoadCh} < ChanLimit);
    assign oLoadReady  = chanInRange && !pendWide[iLoadCh];
    assign loadAccept  = iLoadValid && oLoadReady;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : gChan

        logic [WIDTH-1:0] periodAct;   // Pa
        logic [WIDTH-1:0] highAct;     // Ha
        logic [WIDTH-1:0] periodShd;   // Ps
        logic [WIDTH-1:0] highShd;     // Hs
        logic             pendQ;
        logic [WIDTH-1:0] cnt;
        logic             clkQ;
        logic             tickQ;

        logic [WIDTH-1:0] periodEff;
        logic [WIDTH-1:0] periodNext;
        logic [WIDTH-1:0] periodEffNext;
        logic [WIDTH-1:0] highNext;
        logic [WIDTH-1:0] cntNext;
        logic             wrap;
        logic             transfer;
        logic             accept;

        // Periods below 2 cannot produce a toggling output, so they are
        // clamped to 2.
        assign periodEff = (periodAct < MinPeriod) ? MinPeriod : periodAct;

        // The counter's own wrap uses the values of the period in progress.
        assign wrap    = (cnt >= (periodEff - One));
        assign cntNext = wrap ? '0 : (cnt + One);

        assign accept = loadAccept && (iLoadCh == 4'(gi));

        // A load that is accepted on this edge has pendQ == 0 until the next
        // edge. It therefore cannot also transfer on this edge, and it waits
        // for the following wrap.
        assign transfer = pendQ && (!iEn[gi] || wrap);

        // Values that are active after this edge. A transfer only happens on
        // a wrap or while the channel is disabled. The new high time
        // therefore governs the whole of the period that starts at this
        // edge. The new period length first affects the counter on the
        // next edge.
        assign periodNext    = transfer ? periodShd : periodAct;
        assign highNext      = transfer ? highShd   : highAct;
        assign periodEffNext = (periodNext < MinPeriod) ? MinPeriod : periodNext;

        always_ff @(posedge iClk or negedge iRst_n) begin
            if (!iRst_n) begin
                periodAct <= DefPeriod;
                highAct   <= DefHigh;
                periodShd <= DefPeriod;
                highShd   <= DefHigh;
                pendQ     <= 1'b0;
                cnt       <= DefCnt;
                clkQ      <= 1'b0;
                tickQ     <= 1'b0;
            end else begin
                if (accept) begin
                    periodShd <= iLoadPeriod;
                    highShd   <= iLoadHigh;
                    pendQ     <= 1'b1;
                end else if (transfer) begin
                    pendQ     <= 1'b0;
                end

                periodAct <= periodNext;
                highAct   <= highNext;

                if (iEn[gi]) begin
                    cnt   <= cntNext;
                    // When highNext >= Pe the output stays high, because
                    // cntNext < Pe. When highNext == 0 it stays low.
                    clkQ  <= (cntNext < highNext);
                    tickQ <= (cntNext == '0);
                end else begin
                    // Parked on the last count, so the first enabled edge
                    // wraps to 0 and starts a full period.
                    cnt   <= periodEffNext - One;
                    clkQ  <= 1'b0;
                    tickQ <= 1'b0;
                end
            end
        end

        assign pend[gi]  = pendQ;
        assign oClk[gi]  = clkQ;
        assign oTick[gi] = tickQ;

    end : gChan

endmodule : prog_clk_div

// File: tb/tb_prog_clk_div.sv
// ---------------------------------------------------------------------------
// tb_prog_clk_div
//
// Directed bench for prog_clk_div with WIDTH=8, CHANNELS=2, DEFAULT_PERIOD=4.
// A table of per-edge records holds the inputs, the expected load-ready
// value before the edge, and the expected oClk/oTick after the edge. It
// covers the reset pattern, a period/high-time reload, clamping of a zero
// period, high times of 0 and greater than the period, an out-of-range
// channel index, and a load that lands on a wrap. Hand-written sequences
// then cover reset asserted with a load pending, and disabling and
// re-enabling a channel.
// ---------------------------------------------------------------------------
module tb_prog_clk_div;

    localparam int W  = 8;
    localparam int CH = 2;
    localparam int DP = 4;

    // ---------------- clock / reset ----------------
    logic          iClk = 1'b0;
    logic          iRst_n;
    logic [CH-1:0] iEn;
    logic          iLoadValid;
    logic          oLoadReady;
    logic [3:0]    iLoadCh;
    logic [W-1:0]  iLoadPeriod;
    logic [W-1:0]  iLoadHigh;
    logic [CH-1:0] oClk;
    logic [CH-1:0] oTick;

    always #5 iClk = ~iClk;

    prog_clk_div #(
        .WIDTH         (W),
        .CHANNELS      (CH),
        .DEFAULT_PERIOD(DP)
    ) dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iEn        (iEn),
        .iLoadValid (iLoadValid),
        .oLoadReady (oLoadReady),
        .iLoadCh    (iLoadCh),
        .iLoadPeriod(iLoadPeriod),
        .iLoadHigh  (iLoadHigh),
        .oClk       (oClk),
        .oTick      (oTick)
    );

    // ---------------- scoreboard ----------------
    int nCompared   = 0;
    int nMismatched = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] en;
        logic       lv;
        logic [3:0] ch;
        logic [7:0] p;
        logic [7:0] h;
        logic       rdy;   // oLoadReady before the edge
        logic [1:0] clk;   // {oClk[1], oClk[0]} after the edge
        logic [1:0] tk;    // {oTick[1], oTick[0]} after the edge
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] en, input logic lv, input int ch,
                                input int p, input int h, input logic rdy,
                                input logic [1:0] clk, input logic [1:0] tk);
        vec_t v;
        v.en  = en;
        v.lv  = lv;
        v.ch  = 4'(ch);
        v.p   = 8'(p);
        v.h   = 8'(h);
        v.rdy = rdy;
        v.clk = clk;
        v.tk  = tk;
        return v;
    endfunction

    // Expected {oClk, oTick} and enables for the restart sequence
    logic [3:0]    exp_q[$];
    logic [CH-1:0] en_q[$];

    // ---------------- driver ----------------
    task automatic drive(input vec_t v);
        iEn         = v.en;
        iLoadValid  = v.lv;
        iLoadCh     = v.ch;
        iLoadPeriod = v.p;
        iLoadHigh   = v.h;
    endtask

    initial begin
        // ----- table: edge numbers count from reset release -----
        // Default period 4, high 2: ch0 gives 1,1,0,0, ch1 stays off
        vecs.push_back(mk(2'b01, 0, 0, 0, 0, 1, 2'b01, 2'b01)); // 1
        vecs.push_back(mk(2'b01, 0, 0, 0, 0, 1, 2'b01, 2'b00)); // 2
        vecs.push_back(mk(2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b00)); // 3
        vecs.push_back(mk(2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b00)); // 4
        vecs.push_back(mk(2'b01, 0, 0, 0, 0, 1, 2'b01, 2'b01)); // 5
        vecs.push_back(mk(2'b01, 0, 0, 0, 0, 1, 2'b01, 2'b00)); // 6
        // Load ch0 P=5 H=1 while cnt=1: old period finishes, then 1,0,0,0,0
        vecs.push_back(mk(2'b01, 1, 0, 5, 1, 1, 2'b00, 2'b00)); // 7
        vecs.push_back(mk(2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00)); // 8
        vecs.push_back(mk(2'b01, 0, 0, 0, 0, 0, 2'b01, 2'b01)); // 9 transfer
        vecs.push_back(mk(2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b00)); // 10
        vecs.push_back(mk(2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b00)); // 11
        vecs.push_back(mk(2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b00)); // 12
        vecs.push_back(mk(2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b00)); // 13
        vecs.push_back(mk(2'b01, 0, 0, 0, 0, 1, 2'b01, 2'b01)); // 14
        // Load ch1 P=0 H=1 while disabled, then enable: Pe clamps to 2
        vecs.push_back(mk(2'b01, 1, 1, 0, 1, 1, 2'b00, 2'b00)); // 15
        vecs.push_back(mk(2'b01, 0, 1, 0, 0, 0, 2'b00, 2'b00)); // 16 transfer (disabled)
        vecs.push_back(mk(2'b11, 0, 1, 0, 0, 1, 2'b10, 2'b10)); // 17
        vecs.push_back(mk(2'b11, 0, 1, 0, 0, 1, 2'b00, 2'b00)); // 18
        vecs.push_back(mk(2'b11, 0, 1, 0, 0, 1, 2'b11, 2'b11)); // 19
        vecs.push_back(mk(2'b11, 0, 1, 0, 0, 1, 2'b00, 2'b00)); // 20
        vecs.push_back(mk(2'b11, 0, 1, 0, 0, 1, 2'b10, 2'b10)); // 21
        // Load ch0 P=4 H=0: constant low after wrap at edge 24
        vecs.push_back(mk(2'b11, 1, 0, 4, 0, 1, 2'b00, 2'b00)); // 22
        vecs.push_back(mk(2'b11, 0, 0, 0, 0, 0, 2'b10, 2'b10)); // 23
        vecs.push_back(mk(2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b01)); // 24 transfer
        // Load ch0 P=4 H=9: constant high after wrap at edge 28
        vecs.push_back(mk(2'b11, 1, 0, 4, 9, 1, 2'b10, 2'b10)); // 25
        vecs.push_back(mk(2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b00)); // 26
        vecs.push_back(mk(2'b11, 0, 0, 0, 0, 0, 2'b10, 2'b10)); // 27
        vecs.push_back(mk(2'b11, 0, 0, 0, 0, 0, 2'b01, 2'b01)); // 28 transfer
        vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b11, 2'b10)); // 29
        vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b01, 2'b00)); // 30
        vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b11, 2'b10)); // 31
        // Load ch0 P=2 H=1 on the wrap edge: applied at the next wrap (36)
        vecs.push_back(mk(2'b11, 1, 0, 2, 1, 1, 2'b01, 2'b01)); // 32
        // Out-of-range channel indices are never ready and change nothing
        vecs.push_back(mk(2'b11, 1, 3, 7, 7, 0, 2'b11, 2'b10)); // 33
        vecs.push_back(mk(2'b11, 1, 3, 7, 7, 0, 2'b01, 2'b00)); // 34
        vecs.push_back(mk(2'b11, 1, 2, 7, 7, 0, 2'b11, 2'b10)); // 35
        vecs.push_back(mk(2'b11, 0, 0, 0, 0, 0, 2'b01, 2'b01)); // 36 transfer
        vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b10, 2'b10)); // 37
        vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b01, 2'b01)); // 38
        vecs.push_back(mk(2'b11, 0, 0, 0, 0, 1, 2'b10, 2'b10)); // 39

        // ----- reset state; reset must dominate an asserted enable -----
        iRst_n      = 1'b0;
        iEn         = 2'b01;
        iLoadValid  = 1'b0;
        iLoadCh     = 4'd0;
        iLoadPeriod = '0;
        iLoadHigh   = '0;
        repeat (2) @(posedge iClk);
        #1;
        check("reset oClk", 8'(oClk), 8'h00);
        check("reset oTick", 8'(oTick), 8'h00);
        check("reset oLoadReady", 8'(oLoadReady), 8'h01);
        @(negedge iClk);
        iRst_n = 1'b1;

        // ----- table-driven vectors -----
        for (int r = 0; r < vecs.size(); r++) begin
            drive(vecs[r]);
            #1;
            check($sformatf("edge%0d oLoadReady", r + 1), 8'(oLoadReady), 8'(vecs[r].rdy));
            @(posedge iClk);
            #1;
            check($sformatf("edge%0d oClk", r + 1), 8'(oClk), 8'(vecs[r].clk));
            check($sformatf("edge%0d oTick", r + 1), 8'(oTick), 8'(vecs[r].tk));
        end

        // ----- reset with a pending load (ch0 P=6 H=3) -----
        // ch0 is at cnt=1 of a 2-cycle period. Edge 40 wraps and accepts the
        // load without transferring it.
        iEn         = 2'b11;
        iLoadValid  = 1'b1;
        iLoadCh     = 4'd0;
        iLoadPeriod = 8'd6;
        iLoadHigh   = 8'd3;
        #1;
        check("edge40 oLoadReady", 8'(oLoadReady), 8'h01);
        @(posedge iClk);
        #1;
        check("edge40 oClk", 8'(oClk), 8'h01);
        check("edge40 oTick", 8'(oTick), 8'h01);
        iLoadValid = 1'b0;
        #1;
        check("pending oLoadReady", 8'(oLoadReady), 8'h00);
        @(negedge iClk);
        iRst_n = 1'b0;
        iEn    = 2'b01;
        #1;
        check("async reset oClk", 8'(oClk), 8'h00);
        check("async reset oTick", 8'(oTick), 8'h00);
        check("reset drops pend", 8'(oLoadReady), 8'h01);
        @(posedge iClk);
        #1;
        check("held reset oClk", 8'(oClk), 8'h00);
        @(negedge iClk);
        iRst_n = 1'b1;

        // After release the reset default P=4 H=2 must apply. The load is
        // lost, otherwise the pattern would be 1,1,1,0,0,0. Edges 7-8 run
        // disabled, then re-enabling restarts with a full period.
        // Expected layout: {oClk[1:0], oTick[1:0]}
        en_q = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                 2'b00, 2'b00,
                 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        exp_q = '{4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0101, 4'b0100,
                  4'b0000, 4'b0000,
                  4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0101};
        for (int e = 1; en_q.size() > 0; e++) begin
            logic [3:0] exp;
            iEn = en_q.pop_front();
            @(posedge iClk);
            #1;
            exp = exp_q.pop_front();
            check($sformatf("restart%0d oClk", e), 8'(oClk), 8'(exp[3:2]));
            check($sformatf("restart%0d oTick", e), 8'(oTick), 8'(exp[1:0]));
            @(negedge iClk);
        end

        // ----- final report -----
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule : tb_prog_clk_div
